pclk_phase_seq: RTL and testbench

Four-phase power-clock phase sequencer for the adiabatic datapath. It generates the per-phase interval codes (WAIT, EVAL, HOLD, RECOV) that the power-clock drivers use to ramp the rails feeding the gate cells (nor3b_irr and peers), with each phase lagging the previous one by one quarter-period. Start and stop use req/ack handshakes from the core control. Phases are launched one at a time on start and drained to WAIT on stop, so no rail is ever cut mid-ramp.

---
 rtl/pclk_pkg.sv | 25 ++
 rtl/pclk_quarter_timer.sv | 39 +++
 rtl/pclk_phase_seq.sv | 101 ++++++++++
 tb/tb_pclk_phase_seq.sv | 115 +++++++++++
 4 files changed

// File: rtl/pclk_pkg.sv
// pclk_pkg: shared types and interval decode for the four-phase power-clock sequencer.
package pclk_pkg;

    localparam int NPHASE = 4;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        EVAL  = 2'd1,
        HOLD  = 2'd2,
        RECOV = 2'd3
    } lvl_t;

    typedef enum logic [1:0] {
        IDLE,
        STARTUP,
        RUN,
        DRAIN
    } seq_state_t;

    // Interval i = (q - k) mod 4 maps 0..3 to EVAL, HOLD, RECOV, WAIT, which is simply code = i + 1.
    function automatic lvl_t lvl_of(input logic [1:0] q, input logic [1:0] k);
        return lvl_t'(q - k + 2'd1);
    endfunction

endpackage

// File: rtl/pclk_quarter_timer.sv
// pclk_quarter_timer: tick counter over one quarter-interval and the 2-bit quarter index q.
module pclk_quarter_timer
    import pclk_pkg::*;
#(
    parameter int QW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          run,
    input  logic [QW-1:0] qlen,
    output logic [1:0]    q,
    output logic [QW-1:0] tick,
    output logic          last_tick
);

    logic [1:0]    q_d, q_q;
    logic [QW-1:0] tick_d, tick_q;

    assign last_tick = run && (tick_q == qlen - QW'(1));
    assign q         = q_q;
    assign tick      = tick_q;

    always_comb begin
        tick_d = (clear || last_tick) ? '0 : run ? tick_q + QW'(1) : tick_q;
        q_d    = clear ? 2'd0 : last_tick ? q_q + 2'd1 : q_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q    <= 2'd0;
            tick_q <= '0;
        end else begin
            q_q    <= q_d;
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/pclk_phase_seq.sv
// pclk_phase_seq: four-phase power-clock sequencer with phased start-up and drain-to-WAIT stop.
module pclk_phase_seq
    import pclk_pkg::*;
#(
    parameter int QW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_req,
    input  logic [QW-1:0] quarter_len,
    output logic          start_ack,
    input  logic          stop_req,
    output logic          stop_ack,
    output logic [7:0]    pc_lvl,
    output logic [3:0]    sample_pulse,
    output logic          busy
);

    seq_state_t        state_d, state_q;
    logic [NPHASE-1:0] active_d, active_q;
    logic [QW-1:0]     qlen_d, qlen_q;
    logic              start_ack_d, start_ack_q;
    logic              stop_ack_d, stop_ack_q;
    logic              busy_d, busy_q;
    logic [1:0]        q;
    logic [QW-1:0]     tick;
    logic              last_tick;

    pclk_quarter_timer #(.QW(QW)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (stop_ack_d),
        .run       (state_q != IDLE),
        .qlen      (qlen_q),
        .q         (q),
        .tick      (tick),
        .last_tick (last_tick)
    );

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        qlen_d      = qlen_q;
        start_ack_d = 1'b0;
        stop_ack_d  = 1'b0;
        case (state_q)
            IDLE: if (start_req) begin
                state_d     = STARTUP;
                active_d    = 4'b0001;
                qlen_d      = (quarter_len == '0) ? QW'(1) : quarter_len;
                start_ack_d = 1'b1;
            end
            STARTUP: if (last_tick) begin
                active_d[q + 2'd1] = 1'b1;
                state_d            = (q == 2'd2) ? RUN : STARTUP;
            end
            RUN: state_d = stop_req ? DRAIN : RUN;
            DRAIN: begin
                // A phase parks only as it leaves RECOV, so EVAL and HOLD always run to completion.
                for (int k = 0; k < NPHASE; k++)
                    if (last_tick && lvl_of(q, 2'(k)) == RECOV) active_d[k] = 1'b0;
                if (active_d == '0) begin
                    state_d    = IDLE;
                    stop_ack_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            active_q    <= '0;
            qlen_q      <= QW'(1);
            start_ack_q <= 1'b0;
            stop_ack_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            qlen_q      <= qlen_d;
            start_ack_q <= start_ack_d;
            stop_ack_q  <= stop_ack_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NPHASE; k++) begin
            pc_lvl[2*k +: 2] = active_q[k] ? lvl_of(q, 2'(k)) : WAIT;
            sample_pulse[k]  = active_q[k] && last_tick && (lvl_of(q, 2'(k)) == HOLD);
        end
    end

    assign start_ack = start_ack_q;
    assign stop_ack  = stop_ack_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pclk_phase_seq.sv
// tb_pclk_phase_seq: directed bench for the power-clock phase sequencer with hand-computed drain timing.
module tb_pclk_phase_seq;

    logic       clk;
    logic       reset;
    logic       start_req;
    logic [7:0] quarter_len;
    logic       start_ack;
    logic       stop_req;
    logic       stop_ack;
    logic [7:0] pc_lvl;
    logic [3:0] sample_pulse;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    pclk_phase_seq #(.QW(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_req    (start_req),
        .quarter_len  (quarter_len),
        .start_ack    (start_ack),
        .stop_req     (stop_req),
        .stop_ack     (stop_ack),
        .pc_lvl       (pc_lvl),
        .sample_pulse (sample_pulse),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Start with quarter length ql, raise stop after cycle stop_c (negative: together with start),
    // and expect phase k to park at cycle clr_k and stop_ack to pulse in cycle ack_c.
    task automatic run_seq(input logic [7:0] ql, input int stop_c, input int clr0, input int clr1,
                           input int clr2, input int clr3, input int ack_c);
        int         le;
        int         clr[4];
        int         code;
        logic       act;
        logic [7:0] exp_lvl;
        logic [3:0] exp_sp;
        le  = (ql == 8'd0) ? 1 : int'(ql);
        clr = '{clr0, clr1, clr2, clr3};
        start_req   = 1'b1;
        quarter_len = ql;
        if (stop_c < 0) stop_req = 1'b1;
        @(negedge clk);
        for (int c = 0; c <= ack_c; c++) begin
            for (int k = 0; k < 4; k++) begin
                act  = (c >= k * le) && (c < clr[k]);
                code = act ? ((c / le - k) % 4 + 1) % 4 : 0;
                exp_lvl[2*k +: 2] = 2'(code);
                exp_sp[k]         = act && (code == 2) && (c % le == le - 1);
            end
            check("pc_lvl", pc_lvl, exp_lvl);
            check("sample_pulse", sample_pulse, exp_sp);
            check("start_ack", start_ack, c == 0);
            check("stop_ack", stop_ack, c == ack_c);
            check("busy", busy, c < ack_c);
            if (c == 0) begin
                start_req   = 1'b0;
                quarter_len = ql ^ 8'h5A;
            end
            if (c == stop_c) stop_req = 1'b1;
            if (c == ack_c) stop_req = 1'b0;
            @(negedge clk);
        end
        check("idle_after_stop", {pc_lvl, sample_pulse, busy, start_ack, stop_ack}, 0);
    endtask

    initial begin
        reset       = 1'b1;
        start_req   = 1'b0;
        stop_req    = 1'b0;
        quarter_len = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_state", {pc_lvl, sample_pulse, busy, start_ack, stop_ack}, 0);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_no_start", {pc_lvl, sample_pulse, busy, start_ack, stop_ack}, 0);
        end
        run_seq(8'd3, 23, 33, 36, 27, 30, 36);
        run_seq(8'd0, 7, 11, 12, 9, 10, 12);
        run_seq(8'd2, 10, 14, 16, 18, 12, 18);
        run_seq(8'd2, -1, 14, 8, 10, 12, 14);
        start_req   = 1'b1;
        quarter_len = 8'd2;
        @(negedge clk);
        start_req = 1'b0;
        repeat (4) @(negedge clk);
        check("ph2_eval_before_reset", pc_lvl, 8'b00_01_10_11);
        reset = 1'b1;
        #1;
        check("pc_lvl_on_reset", pc_lvl, 0);
        check("busy_on_reset", {busy, sample_pulse, start_ack, stop_ack}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_seq(8'd4, 15, 28, 32, 20, 24, 32);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
